// File: rtl/aes_round_ctrl_pkg.sv
// Shared types and round-count helpers for the AES round controller.
package aes_package;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_EXP,
    ST_KEY_READY,
    ST_ROUND,
    ST_OUT
  } aes_round_state_t;

  typedef enum logic [1:0] {
    KEY_128     = 2'd0,
    KEY_192     = 2'd1,
    KEY_256     = 2'd2,
    KEY_ILLEGAL = 2'd3
  } aes_key_len_t;

  localparam logic [3:0] AES_NR_128 = 4'd10;
  localparam logic [3:0] AES_NR_192 = 4'd12;
  localparam logic [3:0] AES_NR_256 = 4'd14;

  function automatic logic [3:0] aes_nr(aes_key_len_t len);
    case (len)
      KEY_128: aes_nr = AES_NR_128;
      KEY_192: aes_nr = AES_NR_192;
      KEY_256: aes_nr = AES_NR_256;
      default: aes_nr = '0;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Sequences key expansion and iterative AES rounds; counts delivered blocks.
module aes_round_ctrl
  import aes_package::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned RIDX_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [1:0]        key_len_i,
  input  logic              key_start_i,
  output logic              key_ready_o,
  output logic              key_err_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              dp_load_o,
  output logic              dp_round_en_o,
  output logic [RIDX_W-1:0] dp_round_idx_o,
  output logic              dp_final_o,
  output logic              ks_step_o,
  output logic [RIDX_W-1:0] ks_idx_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  blocks_done_o
);

  aes_round_state_t  state_q, state_d;
  logic [RIDX_W-1:0] idx_q, idx_d;
  logic [RIDX_W-1:0] nr_q, nr_d;
  logic [RIDX_W-1:0] pend_nr_q, pend_nr_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  aes_key_len_t      len;
  logic              key_legal;
  logic [RIDX_W-1:0] new_nr;
  logic              in_ready;
  logic              load;

  assign len    = aes_key_len_t'(key_len_i);
  assign new_nr = RIDX_W'(aes_nr(len));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      nr_q      <= '0;
      pend_nr_q <= '0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      nr_q      <= nr_d;
      pend_nr_q <= pend_nr_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nr_d      = nr_q;
    pend_nr_d = pend_nr_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    err_d     = key_start_i && (len == KEY_ILLEGAL);
    key_legal = key_start_i && (len != KEY_ILLEGAL);
    // a new key request always blocks acceptance so the key wins over data
    in_ready  = !clear && !key_start_i &&
                ((state_q == ST_KEY_READY) ||
                 ((state_q == ST_OUT) && out_ready_i && !pend_q));
    load      = in_ready && in_valid_i;

    case (state_q)
      ST_IDLE: begin
        if (key_legal) begin
          state_d = ST_KEY_EXP;
          idx_d   = RIDX_W'(1);
          nr_d    = new_nr;
        end
      end
      ST_KEY_EXP: begin
        if (key_start_i) begin
          if (key_legal) begin
            idx_d = RIDX_W'(1);
            nr_d  = new_nr;
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        end else if (idx_q == nr_q) begin
          state_d = ST_KEY_READY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + RIDX_W'(1);
        end
      end
      ST_KEY_READY: begin
        if (key_legal) begin
          state_d = ST_KEY_EXP;
          idx_d   = RIDX_W'(1);
          nr_d    = new_nr;
        end else if (load) begin
          state_d = ST_ROUND;
          idx_d   = RIDX_W'(1);
        end
      end
      ST_ROUND: begin
        if (key_legal) begin
          pend_d    = 1'b1;
          pend_nr_d = new_nr;
        end
        if (idx_q == nr_q) begin
          state_d = ST_OUT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + RIDX_W'(1);
        end
      end
      ST_OUT: begin
        if (key_legal) begin
          pend_d    = 1'b1;
          pend_nr_d = new_nr;
        end
        if (out_ready_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          // the pending key is consumed only once the in-flight block has left
          if (pend_d) begin
            state_d = ST_KEY_EXP;
            idx_d   = RIDX_W'(1);
            nr_d    = pend_nr_d;
            pend_d  = 1'b0;
          end else if (load) begin
            state_d = ST_ROUND;
            idx_d   = RIDX_W'(1);
          end else begin
            state_d = ST_KEY_READY;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    if (clear) begin
      state_d   = ST_IDLE;
      idx_d     = '0;
      nr_d      = '0;
      pend_nr_d = '0;
      pend_d    = 1'b0;
      cnt_d     = '0;
      err_d     = 1'b0;
    end
  end

  assign in_ready_o     = in_ready;
  assign dp_load_o      = load;
  assign key_ready_o    = (state_q == ST_KEY_READY) ||
                          (((state_q == ST_ROUND) || (state_q == ST_OUT)) && !pend_q);
  assign key_err_o      = err_q;
  assign out_valid_o    = (state_q == ST_OUT);
  assign dp_round_en_o  = (state_q == ST_ROUND);
  assign dp_round_idx_o = (state_q == ST_ROUND) ? idx_q : '0;
  assign dp_final_o     = (state_q == ST_ROUND) && (idx_q == nr_q);
  assign ks_step_o      = (state_q == ST_KEY_EXP);
  assign ks_idx_o       = (state_q == ST_KEY_EXP) ? idx_q : '0;
  assign busy_o         = (state_q == ST_KEY_EXP) || (state_q == ST_ROUND) ||
                          (state_q == ST_OUT);
  assign blocks_done_o  = cnt_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: cycle-timed transaction model plus latency monitor.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] key_len_i = 2'd0;
  logic       key_start_i = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       out_ready_i = 1'b0;

  logic        key_ready_o, key_err_o, in_ready_o, out_valid_o, dp_load_o;
  logic        dp_round_en_o, dp_final_o, ks_step_o, busy_o;
  logic [3:0]  dp_round_idx_o, ks_idx_o;
  logic [15:0] blocks_done_o;

  logic        s_key_ready_o, s_key_err_o, s_in_ready_o, s_out_valid_o, s_dp_load_o;
  logic        s_dp_round_en_o, s_dp_final_o, s_ks_step_o, s_busy_o;
  logic [3:0]  s_dp_round_idx_o, s_ks_idx_o;
  logic [1:0]  s_blocks_done_o;

  aes_round_ctrl #(.CNT_W(16), .RIDX_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .key_len_i(key_len_i), .key_start_i(key_start_i),
    .key_ready_o(key_ready_o), .key_err_o(key_err_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .dp_load_o(dp_load_o), .dp_round_en_o(dp_round_en_o),
    .dp_round_idx_o(dp_round_idx_o), .dp_final_o(dp_final_o),
    .ks_step_o(ks_step_o), .ks_idx_o(ks_idx_o),
    .busy_o(busy_o), .blocks_done_o(blocks_done_o)
  );

  aes_round_ctrl #(.CNT_W(2), .RIDX_W(4)) dut_w (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .key_len_i(key_len_i), .key_start_i(key_start_i),
    .key_ready_o(s_key_ready_o), .key_err_o(s_key_err_o),
    .in_valid_i(in_valid_i), .in_ready_o(s_in_ready_o),
    .out_valid_o(s_out_valid_o), .out_ready_i(out_ready_i),
    .dp_load_o(s_dp_load_o), .dp_round_en_o(s_dp_round_en_o),
    .dp_round_idx_o(s_dp_round_idx_o), .dp_final_o(s_dp_final_o),
    .ks_step_o(s_ks_step_o), .ks_idx_o(s_ks_idx_o),
    .busy_o(s_busy_o), .blocks_done_o(s_blocks_done_o)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  typedef struct { int ld; int nr; } blk_t;
  blk_t sb_q[$];

  // Reference model: key expansion window, in-flight block window, pending key.
  bit ks_active, inflight, pend, err_flag;
  int ks_start, ks_n, ld, bn, pend_nr;
  int unsigned cnt;

  function automatic int nr_of(input int len);
    return 10 + 2 * len;
  endfunction

  function automatic void mdl_reset();
    ks_active = 0; inflight = 0; pend = 0; err_flag = 0;
    ks_start = 0; ks_n = 0; ld = 0; bn = 0; pend_nr = 0; cnt = 0;
  endfunction

  always @(negedge clk) begin : model
    int c;
    bit ks_now, rd_now, e_out, e_kr, e_ir, e_ld, e_fin, out_hs, in_hs, new_err;
    logic [3:0] e_ksi, e_rdi;
    blk_t b;
    c = cyc;
    if (!reset_n) mdl_reset();
    ks_now = ks_active && c >= ks_start && c < ks_start + ks_n;
    rd_now = inflight && c > ld && c <= ld + bn;
    e_out  = inflight && c > ld + bn;
    e_kr   = ks_active && c >= ks_start + ks_n && !pend;
    e_ir   = !clear && e_kr && !key_start_i && (!inflight || (e_out && out_ready_i));
    e_ld   = e_ir && in_valid_i;
    e_ksi  = ks_now ? 4'(c - ks_start + 1) : 4'd0;
    e_rdi  = rd_now ? 4'(c - ld) : 4'd0;
    e_fin  = rd_now && (c - ld == bn);

    chk("key_ready", key_ready_o, e_kr);
    chk("in_ready", in_ready_o, e_ir);
    chk("dp_load", dp_load_o, e_ld);
    chk("out_valid", out_valid_o, e_out);
    chk("round_en", dp_round_en_o, rd_now);
    chk("round_idx", dp_round_idx_o, e_rdi);
    chk("final", dp_final_o, e_fin);
    chk("ks_step", ks_step_o, ks_now);
    chk("ks_idx", ks_idx_o, e_ksi);
    chk("busy", busy_o, ks_now || inflight);
    chk("key_err", key_err_o, err_flag);
    chk("blocks_done", blocks_done_o, cnt[15:0]);
    chk("w2_blocks_done", s_blocks_done_o, cnt[1:0]);
    chk("w2_bundle",
        {s_key_ready_o, s_in_ready_o, s_dp_load_o, s_out_valid_o, s_dp_round_en_o,
         s_dp_round_idx_o, s_dp_final_o, s_ks_step_o, s_ks_idx_o, s_busy_o, s_key_err_o},
        {e_kr, e_ir, e_ld, e_out, rd_now, e_rdi, e_fin, ks_now, e_ksi, ks_now || inflight,
         err_flag});

    if (reset_n) begin
      if (clear) mdl_reset();
      else begin
        out_hs  = e_out && out_ready_i;
        in_hs   = e_ld;
        new_err = 0;
        if (key_start_i) begin
          if (key_len_i == 2'd3) begin
            new_err = 1;
            if (ks_now) ks_active = 0;
          end else if (inflight) begin
            pend = 1; pend_nr = nr_of(int'(key_len_i));
          end else begin
            ks_active = 1; ks_start = c + 1; ks_n = nr_of(int'(key_len_i));
          end
        end
        if (out_hs) begin
          cnt++;
          inflight = 0;
          if (pend) begin
            ks_active = 1; ks_start = c + 1; ks_n = pend_nr; pend = 0;
          end
        end
        if (in_hs) begin
          inflight = 1; ld = c; bn = ks_n;
          b.ld = c; b.nr = ks_n;
          sb_q.push_back(b);
        end
        err_flag = new_err;
      end
    end
  end

  // Monitor: pops one expected block when a result first appears, checks load->valid latency.
  bit waiting = 0;
  always @(negedge clk) begin : monitor
    blk_t b;
    if (!reset_n || clear) begin
      sb_q.delete();
      waiting = 0;
    end else begin
      if (out_valid_o && !waiting) begin
        if (sb_q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          b = sb_q.pop_front();
          chk("load_to_out_latency", cyc - b.ld, b.nr + 1);
        end
        waiting = 1;
      end
      if (out_valid_o && out_ready_i) waiting = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_key(input int len);
    key_len_i = 2'(len);
    key_start_i = 1'b1;
    tick(1);
    key_start_i = 1'b0;
  endtask

  task automatic wait_key_ready();
    for (int n = 0; n < 200 && !key_ready_o; n++) tick(1);
    chk("key_ready_timeout", key_ready_o, 1);
  endtask

  task automatic wait_out_valid();
    for (int n = 0; n < 200 && !out_valid_o; n++) tick(1);
    chk("out_valid_timeout", out_valid_o, 1);
  endtask

  task automatic send_block();
    in_valid_i = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready_o) break;
    end
    chk("in_accept_timeout", in_ready_o, 1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic stream_blocks(input int nblk, output int got, output int lc[5]);
    got = 0;
    in_valid_i = 1'b1;
    for (int n = 0; n < 600 && got < nblk; n++) begin
      @(negedge clk);
      if (in_ready_o) begin
        lc[got] = cyc;
        got++;
      end
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  initial begin
    int got;
    int lc[5];
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // 128-bit key, single block
    start_key(0);
    wait_key_ready();
    out_ready_i = 1'b1;
    send_block();
    tick(14);
    chk("s1_count", blocks_done_o, 1);

    // 256-bit key, three blocks back-to-back
    start_key(2);
    wait_key_ready();
    stream_blocks(3, got, lc);
    chk("b2b_count", got, 3);
    chk("b2b_gap1", lc[1] - lc[0], 15);
    chk("b2b_gap2", lc[2] - lc[1], 15);
    tick(18);
    chk("s2_count", blocks_done_o, 4);

    // sink stalls for 20 cycles
    out_ready_i = 1'b0;
    send_block();
    wait_out_valid();
    tick(20);
    chk("stall_valid", out_valid_o, 1);
    chk("stall_in_ready", in_ready_o, 0);
    chk("stall_count", blocks_done_o, 4);
    out_ready_i = 1'b1;
    tick(2);
    chk("release_count", blocks_done_o, 5);

    // new 192-bit key requested mid-ROUND
    send_block();
    tick(3);
    start_key(1);
    chk("pending_key_ready", key_ready_o, 0);
    wait_out_valid();
    wait_key_ready();
    chk("s4_count", blocks_done_o, 6);
    tick(2);

    // illegal key length in IDLE and KEY_READY
    clear = 1'b1; tick(1); clear = 1'b0;
    start_key(3);
    chk("idle_err", key_err_o, 1);
    tick(1);
    chk("idle_err_pulse", key_err_o, 0);
    start_key(0);
    wait_key_ready();
    start_key(3);
    chk("ready_err", key_err_o, 1);
    chk("ready_kept", key_ready_o, 1);
    tick(1);
    send_block();
    tick(14);

    // clear at round 5, then reset while OUT is stalled
    send_block();
    tick(4);
    chk("at_round5", dp_round_idx_o, 5);
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("clear_busy", busy_o, 0);
    chk("clear_count", blocks_done_o, 0);
    start_key(0);
    wait_key_ready();
    out_ready_i = 1'b0;
    send_block();
    wait_out_valid();
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("reset_out_valid", out_valid_o, 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // counter wrap on the narrow instance
    start_key(0);
    wait_key_ready();
    out_ready_i = 1'b1;
    stream_blocks(5, got, lc);
    tick(14);
    chk("wrap_got", got, 5);
    chk("wrap_narrow", s_blocks_done_o, 1);
    chk("wrap_wide", blocks_done_o, 5);

    // randomized traffic
    start_key(int'($urandom_range(0, 2)));
    for (int i = 0; i < 800; i++) begin
      key_start_i = ($urandom_range(0, 39) == 0);
      key_len_i   = 2'($urandom_range(0, 3));
      in_valid_i  = ($urandom_range(0, 2) != 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      clear       = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    key_start_i = 1'b0; in_valid_i = 1'b0; clear = 1'b0; out_ready_i = 1'b1;
    tick(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
